clock_manager: RTL
==================

Name: clock_manager

Overview:
- Sits directly behind the iCE40 PLL wrapper, in the PLL output clock domain.
- Qualifies the PLL lock signal and holds the system in reset until lock has been stable for a set number of cycles.
- Generates NUM_CH phase-aligned clock enables (for example a pixel enable and a character enable) by parametrised division.
- Detects PLL lock loss through a glitch filter, re-enters reset, and records the event in a sticky flag and a saturating counter.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before system reset is released (minimum 1).
- LOSS_FILTER_CYCLES, 4: consecutive synchronised-lock-low cycles, while in RUN, that count as a lock loss (minimum 1).
- NUM_CH, 2: number of clock-enable channels.
- DIV_WIDTH, 8: bit width of each channel divisor.
- DIVS, {8'd8, 8'd1}: packed divisors, NUM_CH*DIV_WIDTH bits, channel 0 in the LSBs. Divisor 0 disables that channel.

Ports:
- clock_in  input  1  PLL output clock; the only clock in the block.
- reset  input  1  asynchronous, active-high reset.
- pll_locked  input  1  PLL LOCK output, asynchronous to clock_in.
- clear_lost  input  1  synchronous pulse; clears lock_lost and loss_count.
- sys_reset  output  1  active-high system reset; asserts asynchronously, deasserts synchronously.
- ready  output  1  high only in RUN.
- ce  output  NUM_CH  per-channel clock enables.
- lock_lost  output  1  sticky lock-loss flag.
- loss_count  output  4  saturating count of lock-loss events.

Behaviour:
- Async reset (at any time, including mid-operation):
  - All registers clear immediately, including the two-flop synchroniser and all counters.
  - Outputs go to: sys_reset=1, ready=0, ce=0, lock_lost=0, loss_count=0.
  - State goes to WAIT_LOCK.
- Synchroniser: pll_locked passes through two flops, reset to 0, giving lock_sync (2-cycle latency).
- State machine:
  - WAIT_LOCK: sys_reset=1. If lock_sync=1, go to STABILIZE with stab_cnt=0.
  - STABILIZE: sys_reset=1.
    - lock_sync=0: go to WAIT_LOCK. No filtering applies in this state.
    - stab_cnt==LOCK_STABLE_CYCLES-1 with lock_sync=1: go to RUN.
    - Otherwise: stab_cnt increments.
  - RUN: sys_reset=0, ready=1.
    - loss_cnt increments on each lock_sync=0 cycle and clears on any lock_sync=1 cycle.
    - loss_cnt==LOSS_FILTER_CYCLES-1 with lock_sync=0: go to LOST.
  - LOST: lasts exactly one cycle, then WAIT_LOCK. sys_reset=1, ready=0, ce=0.
- Loss recording:
  - On the RUN->LOST transition edge, lock_lost is set to 1 and loss_count increments, saturating at 15.
  - clear_lost clears both. If clear_lost coincides with a new loss event, the result is lock_lost=1 and loss_count=1 (set wins).
- Startup timing: with pll_locked already high when reset is released, ready rises and sys_reset falls on rising edge LOCK_STABLE_CYCLES+3 after release.
- Clock-enable channels:
  - Each channel has a DIV_WIDTH-bit counter held at 0 in every state except RUN.
  - In RUN, the counter counts 0..DIV_i-1 and wraps.
  - ce[i] = (state==RUN) && (cnt_i==0). This is decoded from registers only; there is no combinational path from any input.
  - All channels therefore pulse on the first RUN cycle and stay phase-aligned from that point.
  - DIV_i=1: ce[i] is constantly high in RUN.
  - DIV_i=0: ce[i] stays 0.
  - Each counter restarts from 0 every time RUN is re-entered.
- Loss timing: a pll_locked low pulse of LOSS_FILTER_CYCLES-1 cycles is ignored. A sustained drop causes sys_reset to rise on edge LOSS_FILTER_CYCLES+2 after the fall.
- Lint: the implementation must elaborate cleanly for NUM_CH=1..8.

Test Plan:
- Startup (LOCK_STABLE_CYCLES=16, pll_locked high from time 0, reset released) -> sys_reset falls and ready rises on edge 19. ce[0] is high from that cycle. ce[1] pulses on edges 19, 27, 35.
- Lock chatter during STABILIZE (pll_locked drops for 1 cycle at stab_cnt=10) -> return to WAIT_LOCK, stab_cnt restarts. Release occurs 16 lock cycles after recovery; lock_lost stays 0.
- Glitch filter (LOSS_FILTER_CYCLES=4, in RUN): 3-cycle low pulse -> no state change, lock_lost=0. 4-cycle low pulse -> sys_reset=1 on edge 6 after the fall, lock_lost=1, loss_count=1, ce=0.
- Saturation and clear: 17 loss/relock cycles -> loss_count=15. A clear_lost pulse -> lock_lost=0, loss_count=0. clear_lost coincident with a loss edge -> lock_lost=1, loss_count=1.
- Divisor corner cases (DIVS={8'd0, 8'd3}) -> ce[1] is never high. ce[0] is high on every 3rd cycle, starting with the first RUN cycle.
- Async reset asserted mid-RUN between clock edges -> sys_reset=1 and ready=0 immediately, with no clock edge needed. After release, the full LOCK_STABLE_CYCLES+3 startup sequence repeats.

Source files
------------

// File: rtl/clock_manager.sv
// PLL lock qualifier and clock-enable generator for the PLL output clock domain.
// Holds sys_reset until lock is stable, filters lock loss and records loss events.
module clock_manager #(
  parameter int unsigned                   LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned                   LOSS_FILTER_CYCLES = 4,
  parameter int unsigned                   NUM_CH             = 2,
  parameter int unsigned                   DIV_WIDTH          = 8,
  parameter logic [NUM_CH*DIV_WIDTH-1:0]   DIVS               = {8'd8, 8'd1}
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic              clear_lost,
  output logic              sys_reset,
  output logic              ready,
  output logic [NUM_CH-1:0] ce,
  output logic              lock_lost,
  output logic [3:0]        loss_count
);

  localparam int unsigned STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int unsigned LOSS_W = (LOSS_FILTER_CYCLES > 1) ? $clog2(LOSS_FILTER_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILIZE,
    RUN,
    LOST
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
  logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic                lock_lost_q, lock_lost_d;
  logic [3:0]          loss_count_q, loss_count_d;
  logic                loss_event;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= WAIT_LOCK;
      stab_cnt_q   <= '0;
      loss_cnt_q   <= '0;
      lock_lost_q  <= 1'b0;
      loss_count_q <= '0;
    end else begin
      sync1_q      <= pll_locked;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      stab_cnt_q   <= stab_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      lock_lost_q  <= lock_lost_d;
      loss_count_q <= loss_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = '0;
    loss_cnt_d = '0;
    loss_event = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (sync2_q) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!sync2_q) begin
          state_d = WAIT_LOCK;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d = RUN;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!sync2_q) begin
          if (loss_cnt_q == LOSS_LAST) begin
            state_d    = LOST;
            loss_event = 1'b1;
          end else begin
            loss_cnt_d = loss_cnt_q + 1'b1;
          end
        end
      end
      LOST: begin
        state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
  end

  // A loss on the same edge as clear_lost wins and restarts the count at one.
  always_comb begin
    lock_lost_d  = lock_lost_q;
    loss_count_d = loss_count_q;
    if (loss_event) begin
      lock_lost_d = 1'b1;
      if (clear_lost) begin
        loss_count_d = 4'd1;
      end else if (loss_count_q != 4'hF) begin
        loss_count_d = loss_count_q + 4'd1;
      end
    end else if (clear_lost) begin
      lock_lost_d  = 1'b0;
      loss_count_d = '0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [DIV_WIDTH-1:0] DIV  = DIVS[g*DIV_WIDTH +: DIV_WIDTH];
    localparam logic [DIV_WIDTH-1:0] LAST = (DIV == '0) ? '0 : DIV - 1'b1;

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    // Counter only advances while staying in RUN, so every RUN entry starts at phase 0.
    always_comb begin
      cnt_d = '0;
      if ((state_q == RUN) && (state_d == RUN) && (cnt_q != LAST)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign ce[g] = (state_q == RUN) && (cnt_q == '0) && (DIV != '0);
  end

  assign sys_reset  = (state_q != RUN);
  assign ready      = (state_q == RUN);
  assign lock_lost  = lock_lost_q;
  assign loss_count = loss_count_q;

endmodule
